mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 72 +++++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port memory arbiter, CPU on port 0 and DMA/loader on port 1.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [2:0]  p0_mode,
    output logic        p0_gnt,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [2:0]  p1_mode,
    output logic        p1_gnt,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addrs,
    output logic [31:0] data_mem_WRITE,
    output logic        mem_WE,
    output logic [2:0]  mem_MODE,
    input  logic [31:0] data_mem_READ
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state, next_state;
    logic tie_to_p1;
`ifdef MEM_ARB_RR_EN
    logic last_grant;
    assign tie_to_p1 = !last_grant;
`else
    assign tie_to_p1 = 1'b0;
`endif
    // A granted port always leaves its grant state, so a lone streamer gets one access per 2 cycles.
    always_comb begin
        next_state = (state == GNT0) ? (p1_req ? GNT1 : IDLE) :
                     (state == GNT1) ? (p0_req ? GNT0 : IDLE) :
                     (p0_req && p1_req) ? (tie_to_p1 ? GNT1 : GNT0) :
                     p0_req ? GNT0 : p1_req ? GNT1 : IDLE;
    end
    assign p0_gnt         = (state == GNT0);
    assign p1_gnt         = (state == GNT1);
    assign mem_addrs      = p0_gnt ? p0_addr  : p1_gnt ? p1_addr  : '0;
    assign data_mem_WRITE = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
    assign mem_WE         = p0_gnt ? p0_we    : p1_gnt ? p1_we    : 1'b0;
    assign mem_MODE       = p0_gnt ? p0_mode  : p1_gnt ? p1_mode  : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            state  <= next_state;
            p0_ack <= p0_gnt;
            p1_ack <= p1_gnt;
            if (p0_gnt) p0_rdata <= data_mem_READ;
            if (p1_gnt) p1_rdata <= data_mem_READ;
        end
    end
`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_grant <= 1'b1;
        else if (next_state == GNT0) last_grant <= 1'b0;
        else if (next_state == GNT1) last_grant <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a word-addressed memory model.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [2:0]  p0_mode, p1_mode;
    logic        p0_gnt, p0_ack, p1_gnt, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addrs, data_mem_WRITE, data_mem_READ;
    logic        mem_WE;
    logic [2:0]  mem_MODE;
    logic [31:0] mem [0:255];
    int total = 0;
    int bad = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_mode(p0_mode),
        .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_mode(p1_mode),
        .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addrs(mem_addrs), .data_mem_WRITE(data_mem_WRITE), .mem_WE(mem_WE),
        .mem_MODE(mem_MODE), .data_mem_READ(data_mem_READ)
    );

    always #5 clk = ~clk;
    assign data_mem_READ = mem[mem_addrs[9:2]];
    always @(posedge clk) if (mem_WE) mem[mem_addrs[9:2]] <= data_mem_WRITE;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h04] = 32'hDEADBEEF;
        mem[8'h0C] = 32'h11111111;
        mem[8'h10] = 32'h22222222;
        reset = 1'b0;
        {p0_req, p0_we, p1_req, p1_we} = '0;
        {p0_addr, p0_wdata, p1_addr, p1_wdata} = '0;
        p0_mode = 3'd0;
        p1_mode = 3'd0;
        #1;
        check("rst_gnt_ack", {p0_gnt, p1_gnt, p0_ack, p1_ack, mem_WE}, 0);
        check("rst_rdata0", p0_rdata, 0);
        check("rst_rdata1", p1_rdata, 0);
        check("rst_addr", mem_addrs, 0);
        tick;
        tick;
        reset = 1'b1;
        tick;
        // single read from port 0
        p0_req = 1'b1; p0_addr = 32'h10; p0_mode = 3'd2;
        tick;
        check("rd_gnt", {p0_gnt, p1_gnt}, 2'b10);
        check("rd_addr", mem_addrs, 32'h10);
        check("rd_mode", mem_MODE, 3'd2);
        check("rd_we", mem_WE, 0);
        check("rd_ack_early", p0_ack, 0);
        p0_req = 1'b0;
        tick;
        check("rd_ack", p0_ack, 1);
        check("rd_gnt_off", {p0_gnt, p1_gnt}, 0);
        check("rd_data", p0_rdata, 32'hDEADBEEF);
        tick;
        check("rd_ack_once", p0_ack, 0);
        check("rd_data_hold", p0_rdata, 32'hDEADBEEF);
        // port 1 write then read back
        p1_req = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hA5A5A5A5; p1_we = 1'b1; p1_mode = 3'd2;
        tick;
        check("wr_gnt", {p0_gnt, p1_gnt}, 2'b01);
        check("wr_we", mem_WE, 1);
        check("wr_addr", mem_addrs, 32'h20);
        check("wr_data", data_mem_WRITE, 32'hA5A5A5A5);
        check("wr_mode", mem_MODE, 3'd2);
        p1_req = 1'b0;
        tick;
        check("wr_ack", p1_ack, 1);
        check("wr_we_off", mem_WE, 0);
        p1_req = 1'b1; p1_we = 1'b0; p1_wdata = 32'h0;
        tick;
        check("rb_gnt", p1_gnt, 1);
        check("rb_we", mem_WE, 0);
        p1_req = 1'b0;
        tick;
        check("rb_ack", p1_ack, 1);
        check("rb_data", p1_rdata, 32'hA5A5A5A5);
        tick;
        // contention: both held, grants alternate starting at port 0
        p0_addr = 32'h30; p1_addr = 32'h40;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("ct_gnt", {p0_gnt, p1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) check("ct_ack", {p0_ack, p1_ack}, (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i == 3) {p0_req, p1_req} = 2'b00;
        end
        check("ct_rdata0", p0_rdata, 32'h11111111);
        tick;
        check("ct_last_ack", {p0_ack, p1_ack}, 2'b01);
        check("ct_rdata1", p1_rdata, 32'h22222222);
        check("ct_idle", {p0_gnt, p1_gnt}, 0);
        // tie right after a port 0 grant
        p0_req = 1'b1; p0_addr = 32'h10;
        tick;
        check("tie_pre_gnt", p0_gnt, 1);
        p0_req = 1'b0;
        tick;
        check("tie_pre_ack", p0_ack, 1);
        p0_req = 1'b1; p1_req = 1'b1;
        tick;
`ifdef MEM_ARB_RR_EN
        check("tie_gnt", {p0_gnt, p1_gnt}, 2'b01);
`else
        check("tie_gnt", {p0_gnt, p1_gnt}, 2'b10);
`endif
        p0_req = 1'b0; p1_req = 1'b0;
        tick;
        tick;
        // reset pulse in the middle of a port 0 grant
        p0_req = 1'b1; p0_addr = 32'h40; p0_we = 1'b1; p0_wdata = 32'h12345678;
        tick;
        check("ra_gnt", p0_gnt, 1);
        check("ra_we", mem_WE, 1);
        reset = 1'b0;
        #1;
        check("ra_async", {p0_gnt, p1_gnt, p0_ack, p1_ack, mem_WE}, 0);
        check("ra_rdata", p0_rdata, 0);
        p0_req = 1'b0; p0_we = 1'b0;
        #2;
        reset = 1'b1;
        tick;
        check("ra_no_ack", {p0_ack, p0_gnt}, 0);
        tick;
        check("ra_no_ack2", {p0_ack, p0_gnt}, 0);
        check("ra_mem", mem[8'h10], 32'h22222222);
        // idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_ctl", {mem_WE, p0_gnt, p1_gnt, p0_ack, p1_ack}, 0);
            check("idle_addr", mem_addrs, 0);
        end
        // single-port streaming: one access every 2 cycles
        p0_req = 1'b1; p0_addr = 32'h30;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("st_gnt", p0_gnt, (i % 2 == 0) ? 1 : 0);
            check("st_ack", p0_ack, (i % 2 == 1) ? 1 : 0);
        end
        p0_req = 1'b0;
        tick;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
